eth_frame_checker: RTL and testbench



---
 rtl/eth_frame_checker_if.sv | 33 +++
 rtl/eth_frame_checker.sv | 166 ++++++++++++++++
 tb/tb_eth_frame_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/eth_frame_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_checker_if
// Purpose  : Egress word stream in/out of the frame checker, with frame status.
// Revision : 1.0 - initial release
// ============================================================================
interface eth_frame_checker_if #(
  parameter int CNT_WIDTH = 16
);
  logic [63:0]          inData;
  logic                 inSop;
  logic                 inEop;
  logic                 inVld;
  logic [63:0]          outData;
  logic                 outSop;
  logic                 outEop;
  logic                 outVld;
  logic                 frameDone;
  logic [2:0]           errCode;
  logic [CNT_WIDTH-1:0] goodCnt;
  logic [CNT_WIDTH-1:0] badCnt;

  modport master (
    output inData, inSop, inEop, inVld,
    input  outData, outSop, outEop, outVld, frameDone, errCode, goodCnt, badCnt
  );

  modport slave (
    input  inData, inSop, inEop, inVld,
    output outData, outSop, outEop, outVld, frameDone, errCode, goodCnt, badCnt
  );
endinterface
`default_nettype wire

// File: rtl/eth_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : eth_frame_checker
// Purpose  : Checks egress frame structure (runt/giant/truncated/orphan),
//            forwards the stream with one cycle latency, reports per-frame
//            status. Macro ETH_CHK_STATS_EN compiles in good/bad counters.
// Revision : 1.0 - initial release
// ============================================================================
module eth_frame_checker #(
  parameter int MIN_WORDS = 8,
  parameter int MAX_WORDS = 190,
  parameter int CNT_WIDTH = 16
) (
  input wire                 clk,
  input wire                 resetN,
  eth_frame_checker_if.slave bus
);
  localparam int                  c_WCNT_W   = $clog2(MAX_WORDS + 2);
  localparam logic [c_WCNT_W-1:0] c_CNT_SAT  = c_WCNT_W'(MAX_WORDS + 1);
  localparam logic [c_WCNT_W-1:0] c_CNT_ONE  = c_WCNT_W'(1);
  localparam logic [c_WCNT_W:0]   c_LEN_ONE  = (c_WCNT_W + 1)'(1);
  localparam logic [c_WCNT_W:0]   c_MIN_LEN  = (c_WCNT_W + 1)'(MIN_WORDS);
  localparam logic [c_WCNT_W:0]   c_MAX_LEN  = (c_WCNT_W + 1)'(MAX_WORDS);
  localparam logic [2:0]          c_ERR_GOOD   = 3'b000;
  localparam logic [2:0]          c_ERR_RUNT   = 3'b001;
  localparam logic [2:0]          c_ERR_GIANT  = 3'b010;
  localparam logic [2:0]          c_ERR_TRUNC  = 3'b011;
  localparam logic [2:0]          c_ERR_ORPHAN = 3'b100;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [c_WCNT_W-1:0] r_word_cnt;
  logic [c_WCNT_W-1:0] w_next_cnt;
  logic [c_WCNT_W:0]   w_len;
  logic                w_fwd;
  logic                w_report;
  logic [2:0]          w_code;

  logic [63:0]         r_out_data;
  logic                r_out_sop;
  logic                r_out_eop;
  logic                r_out_vld;
  logic                r_done;
  logic [2:0]          r_err;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_word_cnt;
    w_fwd        = 1'b0;
    w_report     = 1'b0;
    w_code       = c_ERR_GOOD;
    // Length including the word being presented now.
    w_len        = {1'b0, r_word_cnt} + c_LEN_ONE;
    if (bus.inVld) begin
      case (r_state)
        IDLE: begin
          if (bus.inSop) begin
            w_fwd = 1'b1;
            if (bus.inEop) begin
              w_report = 1'b1;
              w_code   = (MIN_WORDS > 1) ? c_ERR_RUNT : c_ERR_GOOD;
            end else begin
              w_next_state = IN_FRAME;
              w_next_cnt   = c_CNT_ONE;
            end
          end else if (bus.inEop) begin
            w_report = 1'b1;
            w_code   = c_ERR_ORPHAN;
          end
        end
        IN_FRAME: begin
          if (!bus.inSop) begin
            w_fwd = 1'b1;
            if (bus.inEop) begin
              w_report     = 1'b1;
              w_next_state = IDLE;
              w_next_cnt   = '0;
              if (w_len < c_MIN_LEN)
                w_code = c_ERR_RUNT;
              else if (w_len > c_MAX_LEN)
                w_code = c_ERR_GIANT;
              else
                w_code = c_ERR_GOOD;
            end else if (r_word_cnt != c_CNT_SAT) begin
              w_next_cnt = r_word_cnt + c_CNT_ONE;
            end
          end else begin
            // A new SOP closes the open frame as truncated.
            w_report = 1'b1;
            w_code   = c_ERR_TRUNC;
            if (bus.inEop) begin
              w_next_state = IDLE;
              w_next_cnt   = '0;
            end else begin
              w_fwd      = 1'b1;
              w_next_cnt = c_CNT_ONE;
            end
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_word_cnt <= '0;
      r_out_data <= '0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= c_ERR_GOOD;
    end else begin
      r_state    <= w_next_state;
      r_word_cnt <= w_next_cnt;
      r_out_vld  <= w_fwd;
      r_out_sop  <= w_fwd & bus.inSop;
      r_out_eop  <= w_fwd & bus.inEop;
      r_done     <= w_report;
      if (w_fwd)
        r_out_data <= bus.inData;
      if (w_report)
        r_err <= w_code;
    end
  end

  assign bus.outData   = r_out_data;
  assign bus.outSop    = r_out_sop;
  assign bus.outEop    = r_out_eop;
  assign bus.outVld    = r_out_vld;
  assign bus.frameDone = r_done;
  assign bus.errCode   = r_err;

`ifdef ETH_CHK_STATS_EN
  logic [CNT_WIDTH-1:0] r_good_cnt;
  logic [CNT_WIDTH-1:0] r_bad_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_good_cnt <= '0;
      r_bad_cnt  <= '0;
    end else if (w_report) begin
      if (w_code == c_ERR_GOOD) begin
        if (r_good_cnt != '1)
          r_good_cnt <= r_good_cnt + CNT_WIDTH'(1);
      end else if (r_bad_cnt != '1) begin
        r_bad_cnt <= r_bad_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign bus.goodCnt = r_good_cnt;
  assign bus.badCnt  = r_bad_cnt;
`else
  assign bus.goodCnt = '0;
  assign bus.badCnt  = '0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_eth_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_frame_checker
// Purpose  : Randomized frame-level stimulus checked against a frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_frame_checker;
  localparam int MIN_WORDS = 8;
  localparam int MAX_WORDS = 190;
  localparam int CNT_WIDTH = 16;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  eth_frame_checker_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

  eth_frame_checker #(
    .MIN_WORDS(MIN_WORDS),
    .MAX_WORDS(MAX_WORDS),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  typedef struct {
    logic        vld, sop, eop;
    logic [63:0] data;
    logic        ev, es, ee;
    logic [63:0] ed;
    logic        done;
    logic [2:0]  code;
  } cyc_t;

  cyc_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   good_exp = 0;
  int   bad_exp = 0;
  logic [2:0] last_code = 3'b000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(input logic sop, input logic eop, input logic [63:0] data,
                               input logic fwd, input logic done, input logic [2:0] code);
    cyc_t c;
    int   n;
    // Idle cycles carry random junk on the other inputs; it must be ignored.
    n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
    for (int g = 0; g < n; g++) begin
      c = '{vld: 1'b0, sop: 1'($urandom), eop: 1'($urandom), data: {$urandom, $urandom},
            ev: 1'b0, es: 1'b0, ee: 1'b0, ed: 64'h0, done: 1'b0, code: 3'b000};
      q.push_back(c);
    end
    c = '{vld: 1'b1, sop: sop, eop: eop, data: data,
          ev: fwd, es: sop, ee: eop, ed: data, done: done, code: code};
    q.push_back(c);
  endfunction

  function automatic logic [2:0] len_code(input int len);
    if (len < MIN_WORDS) return 3'b001;
    if (len > MAX_WORDS) return 3'b010;
    return 3'b000;
  endfunction

  // Complete frame; if a frame is still open, its SOP reports that one as truncated.
  function automatic void gen_frame(input int len, input bit pend, input bit seq);
    for (int w = 0; w < len; w++) begin
      logic [63:0] d;
      logic        dn;
      logic [2:0]  cd;
      d  = seq ? 64'(w) : {$urandom, $urandom};
      dn = (pend && w == 0) || (w == len - 1);
      cd = (pend && w == 0) ? 3'b011 : len_code(len);
      push(w == 0, w == len - 1, d, 1'b1, dn, cd);
    end
  endfunction

  function automatic void gen_open(input int len, input bit pend);
    for (int w = 0; w < len; w++)
      push(w == 0, 1'b0, {$urandom, $urandom}, 1'b1, pend && w == 0, 3'b011);
  endfunction

  function automatic void gen_drop();
    push(1'b1, 1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 3'b011);
  endfunction

  function automatic void gen_orphan(input logic eop, input logic [63:0] d);
    push(1'b0, eop, d, 1'b0, eop, 3'b100);
  endfunction

  function automatic int rand_len(input bit pend);
    int r, len;
    r = $urandom_range(0, 9);
    if (r < 3)      len = $urandom_range(1, 7);
    else if (r < 6) len = $urandom_range(8, 20);
    else if (r < 8) len = $urandom_range(185, 195);
    else begin
      case ($urandom_range(0, 3))
        0:       len = MIN_WORDS - 1;
        1:       len = MIN_WORDS;
        2:       len = MAX_WORDS;
        default: len = MAX_WORDS + 1;
      endcase
    end
    if (pend && len < 2) len = 2;
    return len;
  endfunction

  task automatic run_queue();
    for (int i = 0; i < q.size(); i++) begin
      bus.inVld  = q[i].vld;
      bus.inSop  = q[i].sop;
      bus.inEop  = q[i].eop;
      bus.inData = q[i].data;
      @(negedge clk);
      if (q[i].done) begin
        last_code = q[i].code;
        if (q[i].code == 3'b000) good_exp++;
        else                     bad_exp++;
      end
      check("outVld", 64'(bus.outVld), 64'(q[i].ev));
      if (q[i].ev) begin
        check("outData", bus.outData, q[i].ed);
        check("outSop", 64'(bus.outSop), 64'(q[i].es));
        check("outEop", 64'(bus.outEop), 64'(q[i].ee));
      end
      check("frameDone", 64'(bus.frameDone), 64'(q[i].done));
      check("errCode", 64'(bus.errCode), 64'(last_code));
`ifdef ETH_CHK_STATS_EN
      check("goodCnt", 64'(bus.goodCnt), 64'(good_exp));
      check("badCnt", 64'(bus.badCnt), 64'(bad_exp));
`else
      check("goodCnt", 64'(bus.goodCnt), 64'h0);
      check("badCnt", 64'(bus.badCnt), 64'h0);
`endif
    end
    bus.inVld = 1'b0;
    q.delete();
  endtask

  task automatic check_cleared(input string phase);
    check({phase, "_outVld"}, 64'(bus.outVld), 64'h0);
    check({phase, "_outSop"}, 64'(bus.outSop), 64'h0);
    check({phase, "_outEop"}, 64'(bus.outEop), 64'h0);
    check({phase, "_outData"}, bus.outData, 64'h0);
    check({phase, "_frameDone"}, 64'(bus.frameDone), 64'h0);
    check({phase, "_errCode"}, 64'(bus.errCode), 64'h0);
    check({phase, "_goodCnt"}, 64'(bus.goodCnt), 64'h0);
    check({phase, "_badCnt"}, 64'(bus.badCnt), 64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    bus.inVld  = 1'b0;
    bus.inSop  = 1'b0;
    bus.inEop  = 1'b0;
    bus.inData = 64'h0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    resetN = 1'b1;
    @(negedge clk);

    // Directed scenarios first, then a random mix of frame shapes.
    gen_frame(8, 0, 1);
    gen_frame(8, 0, 1);
    gen_frame(3, 0, 0);
    gen_frame(191, 0, 0);
    gen_open(5, 0);
    gen_frame(8, 1, 0);
    gen_orphan(1'b1, 64'hDEAD);
    gen_orphan(1'b0, 64'hBEEF);
    gen_frame(10, 0, 0);
    gen_open(3, 0);
    gen_drop();
    gen_frame(1, 0, 0);
    pend = 0;
    for (int s = 0; s < 40; s++) begin
      int t;
      t = $urandom_range(0, 4);
      if (pend && t >= 3) t = 0;
      case (t)
        0, 1: begin gen_frame(rand_len(pend), pend, 0); pend = 0; end
        2: begin gen_open($urandom_range(1, 12), pend); pend = 1; end
        3: begin
          if ($urandom_range(0, 1) == 0) gen_orphan(1'($urandom), {$urandom, $urandom});
          else gen_frame(1, 0, 0);
        end
        default: begin
          if (pend) begin gen_drop(); pend = 0; end
          else gen_orphan(1'b1, {$urandom, $urandom});
        end
      endcase
      if (pend && s == 39) begin gen_drop(); pend = 0; end
    end
    run_queue();

    // Reset in the middle of a frame: everything clears, no report for it.
    for (int w = 0; w < 5; w++) begin
      bus.inVld  = 1'b1;
      bus.inSop  = (w == 0);
      bus.inEop  = 1'b0;
      bus.inData = {$urandom, $urandom};
      @(negedge clk);
    end
    #2 resetN = 1'b0;
    #1 check_cleared("midreset");
    @(negedge clk);
    bus.inVld = 1'b0;
    @(negedge clk);
    check_cleared("held");
    resetN    = 1'b1;
    good_exp  = 0;
    bad_exp   = 0;
    last_code = 3'b000;
    @(negedge clk);
    gen_frame(8, 0, 1);
    run_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
